// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl
//   Initiator side of the address-counter handshake. For every pixel of a
//   WIN x WIN window it requests a read address, reads the pixel from SRAM and
//   stores it in the window register. Once the window is complete it is
//   presented to the edge datapath. The returned result is written to the
//   address obtained from a write-address request. This repeats until the
//   counter flags the last write address.
//
// Ports
//   clk, n_rst             clock (rising edge), asynchronous active-low reset
//   i_start                begin a frame (honoured only when idle)
//   o_inc_raddr            one-cycle read-address request
//   i_r_ready, i_raddr     read address valid pulse and address
//   o_inc_waddr            one-cycle write-address request
//   i_w_ready, i_waddr     write address valid pulse and address
//   i_done                 last-write flag, qualified by i_w_ready
//   o_mem_read/o_mem_write SRAM strobes, held while i_mem_busy
//   o_mem_addr/o_mem_wdata SRAM address and write data
//   i_mem_rdata/i_mem_busy SRAM read data and stall
//   o_win_valid, o_window  window complete and its pixels (k-th fetch in slot k)
//   i_result_valid/i_result datapath result handshake
//   o_busy                 high whenever not idle
//   o_frame_done           one-cycle pulse after the final write
//   o_err                  sticky timeout flag, cleared only by reset
module window_fetch_ctrl #(
  parameter int unsigned WIN         = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         i_start,
  output logic                         o_inc_raddr,
  input  logic                         i_r_ready,
  input  logic [ADDR_W-1:0]            i_raddr,
  output logic                         o_inc_waddr,
  input  logic                         i_w_ready,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic                         i_done,
  output logic                         o_mem_read,
  output logic                         o_mem_write,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [DATA_W-1:0]            o_mem_wdata,
  input  logic [DATA_W-1:0]            i_mem_rdata,
  input  logic                         i_mem_busy,
  output logic                         o_win_valid,
  output logic [WIN*WIN*DATA_W-1:0]    o_window,
  input  logic                         i_result_valid,
  input  logic [DATA_W-1:0]            i_result,
  output logic                         o_busy,
  output logic                         o_frame_done,
  output logic                         o_err
);

  localparam int unsigned NPIX  = WIN * WIN;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, REQ_R, WAIT_R, RD, WIN_OUT, REQ_W, WAIT_W, WR, FDONE
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   pix_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               done_lat;
  logic               tmo_hit;
  logic               last_pix;
  logic               capture;
  logic               timeout;

  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign last_pix = (pix_cnt == CNT_W'(NPIX - 1));

  // A handshake event in the same cycle as the timeout wins over the timeout.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE:    if (i_start) state_next = REQ_R;
      REQ_R:   state_next = WAIT_R;
      WAIT_R: begin
        if (i_r_ready) state_next = RD;
        else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      RD: begin
        if (!i_mem_busy) begin
          capture    = 1'b1;
          state_next = last_pix ? WIN_OUT : REQ_R;
        end else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      WIN_OUT: if (i_result_valid) state_next = REQ_W;
      REQ_W:   state_next = WAIT_W;
      WAIT_W: begin
        if (i_w_ready) state_next = WR;
        else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      WR: begin
        if (!i_mem_busy) state_next = done_lat ? FDONE : REQ_R;
        else if (tmo_hit) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      FDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the
  // state register and drop in the same cycle the state is left.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      tmo_cnt      <= '0;
      done_lat     <= 1'b0;
      o_inc_raddr  <= 1'b0;
      o_inc_waddr  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_win_valid  <= 1'b0;
      o_window     <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state   <= state_next;
      tmo_cnt <= (state_next != state) ? '0 : tmo_cnt + TMO_W'(1);

      if (timeout) o_err <= 1'b1;

      // Clearing on start also discards a partial window left by a timeout.
      if (state == IDLE && i_start) pix_cnt <= '0;

      if (state == WAIT_R && i_r_ready) o_mem_addr <= i_raddr;
      if (state == WAIT_W && i_w_ready) begin
        o_mem_addr <= i_waddr;
        done_lat   <= i_done;
      end

      if (capture) begin
        for (int unsigned k = 0; k < NPIX; k++) begin
          if (32'(pix_cnt) == k) o_window[k*DATA_W +: DATA_W] <= i_mem_rdata;
        end
        pix_cnt <= pix_cnt + CNT_W'(1);
      end

      if (state == WIN_OUT && i_result_valid) begin
        o_mem_wdata <= i_result;
        pix_cnt     <= '0;
      end

      o_inc_raddr  <= (state_next == REQ_R);
      o_inc_waddr  <= (state_next == REQ_W);
      o_mem_read   <= (state_next == RD);
      o_mem_write  <= (state_next == WR);
      o_win_valid  <= (state_next == WIN_OUT);
      o_frame_done <= (state_next == FDONE);
      o_busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// Directed bench for window_fetch_ctrl: plays the address counter, SRAM and
// datapath by hand and compares outputs with hand-computed values.
module tb_window_fetch_ctrl;

  localparam int unsigned WIN = 4, DATA_W = 8, ADDR_W = 32, TIMEOUT_CYC = 1024;
  localparam int unsigned NPIX = WIN * WIN;

  logic                      clk = 1'b0;
  logic                      n_rst;
  logic                      i_start, i_r_ready, i_w_ready, i_done;
  logic [ADDR_W-1:0]         i_raddr, i_waddr;
  logic [DATA_W-1:0]         i_mem_rdata, i_result;
  logic                      i_mem_busy, i_result_valid;
  logic                      o_inc_raddr, o_inc_waddr, o_mem_read, o_mem_write;
  logic [ADDR_W-1:0]         o_mem_addr;
  logic [DATA_W-1:0]         o_mem_wdata;
  logic                      o_win_valid, o_busy, o_frame_done, o_err;
  logic [NPIX*DATA_W-1:0]    o_window;
  logic [NPIX*DATA_W-1:0]    exp_win;

  int n_checks = 0;
  int n_pass   = 0;

  window_fetch_ctrl #(.WIN(WIN), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start),
    .o_inc_raddr(o_inc_raddr), .i_r_ready(i_r_ready), .i_raddr(i_raddr),
    .o_inc_waddr(o_inc_waddr), .i_w_ready(i_w_ready), .i_waddr(i_waddr), .i_done(i_done),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_busy(i_mem_busy),
    .o_win_valid(o_win_valid), .o_window(o_window),
    .i_result_valid(i_result_valid), .i_result(i_result),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_inc_r();
    int n = 0;
    while (!o_inc_raddr && n < 40) begin
      tick();
      n++;
    end
    check("inc_raddr_seen", o_inc_raddr, 1);
  endtask

  // Answer one read request after lat cycles; SRAM stalls busy_n cycles.
  task automatic serve_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                            input int busy_n, input int lat, input bit stray);
    int n;
    wait_inc_r();
    tick();
    check("inc_raddr_1cyc", o_inc_raddr, 0);
    if (stray) begin
      // Events that must be ignored while waiting for the read address.
      i_w_ready = 1'b1; i_waddr = 32'hDEAD; i_result_valid = 1'b1; i_start = 1'b1;
      tick();
      i_w_ready = 1'b0; i_result_valid = 1'b0; i_start = 1'b0;
      repeat (lat - 2) tick();
    end else begin
      repeat (lat - 1) tick();
    end
    i_r_ready = 1'b1; i_raddr = addr; i_mem_rdata = data;
    tick();
    i_r_ready = 1'b0;
    check("rd_strobe", o_mem_read, 1);
    check("rd_addr", o_mem_addr, addr);
    n = 0;
    while (o_mem_read && n < 20) begin
      n++;
      i_mem_busy = (n <= busy_n);
      tick();
    end
    i_mem_busy = 1'b0;
    check("rd_cycles", n, busy_n + 1);
  endtask

  task automatic serve_write(input logic [ADDR_W-1:0] addr, input bit done,
                             input logic [DATA_W-1:0] data, input int busy_n, input int lat);
    int n = 0;
    while (!o_inc_waddr && n < 40) begin
      tick();
      n++;
    end
    check("inc_waddr_seen", o_inc_waddr, 1);
    tick();
    check("inc_waddr_1cyc", o_inc_waddr, 0);
    repeat (lat - 1) tick();
    i_w_ready = 1'b1; i_waddr = addr; i_done = done;
    tick();
    i_w_ready = 1'b0; i_done = 1'b0;
    check("wr_strobe", o_mem_write, 1);
    check("wr_addr", o_mem_addr, addr);
    check("wr_data", o_mem_wdata, data);
    n = 0;
    while (o_mem_write && n < 20) begin
      n++;
      i_mem_busy = (n <= busy_n);
      tick();
    end
    i_mem_busy = 1'b0;
    check("wr_cycles", n, busy_n + 1);
  endtask

  initial begin
    int n;
    bit seen;
    n_rst = 1'b0;
    i_start = 0; i_r_ready = 0; i_w_ready = 0; i_done = 0; i_raddr = '0; i_waddr = '0;
    i_mem_rdata = '0; i_result = '0; i_mem_busy = 0; i_result_valid = 0;
    exp_win = '0;
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    check("rst_busy", o_busy, 0);
    check("rst_inc_raddr", o_inc_raddr, 0);
    check("rst_mem_read", o_mem_read, 0);
    check("rst_mem_write", o_mem_write, 0);
    check("rst_window", o_window, 0);
    check("rst_err", o_err, 0);
    check("rst_win_valid", o_win_valid, 0);

    // T1/T2: first pixel, SRAM stalls 3 cycles
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_busy", o_busy, 1);
    serve_read(32'd0, 8'h5A, 3, 5, 1'b1);
    exp_win[7:0] = 8'h5A;
    check("slot0", o_window, exp_win);
    check("next_req_r", o_inc_raddr, 1);
    check("no_win_valid", o_win_valid, 0);

    // T3: remaining pixels
    for (int k = 1; k < 16; k++) begin
      serve_read(32'(k), 8'(k), k % 3, 5 + (k % 2), 1'b0);
      exp_win[k*8 +: 8] = 8'(k);
    end
    check("win_valid", o_win_valid, 1);
    check("window_full", o_window, exp_win);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen |= o_inc_raddr;
      tick();
    end
    check("no_17th_req", seen, 0);
    check("win_valid_held", o_win_valid, 1);
    check("window_stable", o_window, exp_win);

    // T4: result write, not last
    i_result = 8'hAB; i_result_valid = 1'b1;
    tick();
    i_result_valid = 1'b0;
    check("win_valid_clr", o_win_valid, 0);
    serve_write(32'd200000, 1'b0, 8'hAB, 1, 5);
    check("after_wr_req_r", o_inc_raddr, 1);
    check("no_frame_done", o_frame_done, 0);

    // T5: second window, last write
    for (int k = 0; k < 16; k++) begin
      serve_read(32'(16 + k), 8'(8'h10 + k), 0, 5, 1'b0);
      exp_win[k*8 +: 8] = 8'(8'h10 + k);
    end
    check("window2", o_window, exp_win);
    i_result = 8'h3C; i_result_valid = 1'b1;
    tick();
    i_result_valid = 1'b0;
    serve_write(32'd200001, 1'b1, 8'h3C, 0, 5);
    check("frame_done", o_frame_done, 1);
    tick();
    check("frame_done_1cyc", o_frame_done, 0);
    check("idle_busy", o_busy, 0);
    check("window_retained", o_window, exp_win);
    check("err_clear", o_err, 0);

    // T6: timeout in WAIT_R after two pixels
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    serve_read(32'd0, 8'hE0, 0, 5, 1'b0);
    serve_read(32'd1, 8'hE1, 0, 5, 1'b0);
    exp_win[7:0] = 8'hE0;
    exp_win[15:8] = 8'hE1;
    wait_inc_r();
    n = 0;
    while (o_busy && n < 1200) begin
      tick();
      n++;
    end
    check("tmo_cycles", n, TIMEOUT_CYC + 1);
    check("tmo_err", o_err, 1);
    check("tmo_read_off", o_mem_read, 0);
    check("tmo_inc_off", o_inc_raddr, 0);

    // Restart after timeout: count restarts at slot 0, error stays
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("err_sticky", o_err, 1);
    serve_read(32'd0, 8'h77, 0, 5, 1'b0);
    exp_win[7:0] = 8'h77;
    check("restart_slot0", o_window, exp_win);

    // Reset while in RD
    wait_inc_r();
    tick();
    i_r_ready = 1'b1; i_raddr = 32'd5; i_mem_busy = 1'b1;
    tick();
    i_r_ready = 1'b0;
    check("rd_before_rst", o_mem_read, 1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_rd_off", o_mem_read, 0);
    check("rst_rd_busy", o_busy, 0);
    check("rst_rd_err", o_err, 0);
    check("rst_rd_window", o_window, 0);
    tick();
    n_rst = 1'b1;
    i_mem_busy = 1'b0;
    tick();
    check("post_rst_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
